// File: rtl/fpga_test_step_div_58s_29ns_30_seq.sv
// ---------------------------------------------------------------------------
// fpga_test_step_div_58s_29ns_30_seq
//
// Sequential signed-by-unsigned restoring divider with an ap_start/ap_done
// block handshake. It divides a 58-bit signed dividend by a 29-bit unsigned
// divisor and produces a 30-bit signed quotient (truncated toward zero) and
// remainder (sign of the dividend). It computes one quotient bit per clock.
//
// Ports:
//   ap_clk    in   clock, rising edge
//   ap_rst_n  in   asynchronous active-low reset
//   ap_start  in   request, sampled only while idle
//   ap_ready  out  operands consumed this cycle (ap_start & ap_idle)
//   ap_idle   out  block is in IDLE
//   ap_done   out  one-cycle pulse, results valid
//   din0      in   dividend (signed, din0_WIDTH)
//   din1      in   divisor (unsigned, din1_WIDTH)
//   dout      out  quotient (signed, dout_WIDTH)
//   rem       out  remainder (signed, dout_WIDTH)
//   dz        out  divide-by-zero flag for the current result
//   ovf       out  quotient overflow flag for the current result
//
// Build option: define FPGA_TEST_STEP_DIV_SAT_EN to saturate an overflowing
// quotient and report it on ovf. Without it the quotient wraps to its low
// dout_WIDTH bits and ovf stays 0.
// ---------------------------------------------------------------------------
module fpga_test_step_div_58s_29ns_30_seq #(
  parameter int din0_WIDTH = 58,
  parameter int din1_WIDTH = 29,
  parameter int dout_WIDTH = 30
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic [dout_WIDTH-1:0] rem,
  output logic                  dz,
  output logic                  ovf
);

  localparam int CNT_W = $clog2(din0_WIDTH);
  localparam int R_W   = din1_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(din0_WIDTH - 1);
  localparam logic [dout_WIDTH-1:0] SAT_POS = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] SAT_NEG = {1'b1, {(dout_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // The dividend magnitude shifts out of the top of n_reg while quotient
  // bits shift in at the bottom, so after the last iteration n holds the
  // unsigned quotient.
  logic [din0_WIDTH-1:0] n_reg;
  logic [R_W-1:0]        r_reg;
  logic [din1_WIDTH-1:0] d_reg;
  logic                  neg_reg;
  logic                  dz_flag_reg;
  logic [CNT_W-1:0]      cnt_reg;

  logic [dout_WIDTH-1:0] dout_reg;
  logic [dout_WIDTH-1:0] rem_reg;
  logic                  dz_reg;
  logic                  ovf_reg;
  logic                  done_reg;

  // -------------------------------------------------------------------------
  // One restoring iteration
  // -------------------------------------------------------------------------
  logic [R_W-1:0]        r_shift;
  logic [R_W-1:0]        d_ext;
  logic [R_W-1:0]        r_next;
  logic                  ge;
  logic [din0_WIDTH-1:0] n_next;

  always_comb begin
    r_shift = {r_reg[R_W-2:0], n_reg[din0_WIDTH-1]};
    d_ext   = {1'b0, d_reg};
    // r_reg stays below d, so its top bit is always clear; including it
    // keeps the compare exact for the full shifted value {r, msb(n)}.
    ge      = r_reg[R_W-1] | (r_shift >= d_ext);
    r_next  = ge ? (r_shift - d_ext) : r_shift;
    n_next  = {n_reg[din0_WIDTH-2:0], ge};
  end

  // -------------------------------------------------------------------------
  // Result formation from the final iteration
  // -------------------------------------------------------------------------
  logic [dout_WIDTH-1:0] q_low;
  logic [dout_WIDTH-1:0] q_res;
  logic [dout_WIDTH-1:0] rem_res;
  logic                  ovf_res;

`ifdef FPGA_TEST_STEP_DIV_SAT_EN
  localparam logic [din0_WIDTH-1:0] POS_LIM =
    {{(din0_WIDTH-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  localparam logic [din0_WIDTH-1:0] NEG_LIM =
    {{(din0_WIDTH-dout_WIDTH){1'b0}}, 1'b1, {(dout_WIDTH-1){1'b0}}};
  logic q_ovf;

  // A negative quotient may reach magnitude 2^(W-1); a positive one only
  // 2^(W-1)-1.
  always_comb begin
    q_ovf = neg_reg ? (n_next > NEG_LIM) : (n_next > POS_LIM);
  end
`endif

  always_comb begin
    // Low bits of the negated magnitude equal the negated low bits, so the
    // wrapped quotient never needs the full-width negation.
    q_low   = neg_reg ? -n_next[dout_WIDTH-1:0] : n_next[dout_WIDTH-1:0];
    q_res   = q_low;
    rem_res = neg_reg ? -r_next : r_next;
    ovf_res = 1'b0;
    if (dz_flag_reg) begin
      q_res   = neg_reg ? SAT_NEG : SAT_POS;
      rem_res = '0;
    end
`ifdef FPGA_TEST_STEP_DIV_SAT_EN
    else if (q_ovf) begin
      q_res   = neg_reg ? SAT_NEG : SAT_POS;
      ovf_res = 1'b1;
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (ap_start) state_next = S_CALC;
      S_CALC:  if (cnt_reg == '0) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      n_reg       <= '0;
      r_reg       <= '0;
      d_reg       <= '0;
      neg_reg     <= 1'b0;
      dz_flag_reg <= 1'b0;
      cnt_reg     <= '0;
      dout_reg    <= '0;
      rem_reg     <= '0;
      dz_reg      <= 1'b0;
      ovf_reg     <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (ap_start) begin
            n_reg       <= din0[din0_WIDTH-1] ? -din0 : din0;
            neg_reg     <= din0[din0_WIDTH-1];
            d_reg       <= din1;
            dz_flag_reg <= (din1 == '0);
            r_reg       <= '0;
            cnt_reg     <= CNT_LOAD;
          end
        end
        S_CALC: begin
          n_reg <= n_next;
          r_reg <= r_next;
          if (cnt_reg == '0) begin
            // Results land together with the entry into DONE, so they are
            // valid during the ap_done cycle.
            done_reg <= 1'b1;
            dout_reg <= q_res;
            rem_reg  <= rem_res;
            dz_reg   <= dz_flag_reg;
            ovf_reg  <= ovf_res;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ap_idle  = (state_reg == S_IDLE);
  assign ap_ready = ap_start & ap_idle;
  assign ap_done  = done_reg;
  assign dout     = dout_reg;
  assign rem      = rem_reg;
  assign dz       = dz_reg;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_fpga_test_step_div_58s_29ns_30_seq.sv
// ---------------------------------------------------------------------------
// Testbench for fpga_test_step_div_58s_29ns_30_seq. Expected results come
// from signed 64-bit arithmetic and are queued at acceptance; a monitor pops
// and compares on every ap_done, including the acceptance-to-done latency.
// ---------------------------------------------------------------------------
module tb_fpga_test_step_div_58s_29ns_30_seq;

  logic        ap_clk;
  logic        ap_rst_n = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_ready;
  logic        ap_idle;
  logic        ap_done;
  logic [57:0] din0 = '0;
  logic [28:0] din1 = '0;
  logic [29:0] dout;
  logic [29:0] rem;
  logic        dz;
  logic        ovf;

  fpga_test_step_div_58s_29ns_30_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .ap_start (ap_start),
    .ap_ready (ap_ready),
    .ap_idle  (ap_idle),
    .ap_done  (ap_done),
    .din0     (din0),
    .din1     (din1),
    .dout     (dout),
    .rem      (rem),
    .dz       (dz),
    .ovf      (ovf)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [29:0] dout;
    logic [29:0] rem;
    logic        dz;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed division of the sign-extended operands.
  function automatic exp_t model(input logic [57:0] a, input logic [28:0] b, input int acc);
    exp_t e;
    longint sa, sb_l, qq, rr;
    logic [63:0] qb, rb;
    sa   = $signed({{6{a[57]}}, a});
    sb_l = $signed({35'd0, b});
    e.acc = acc;
    e.dz  = 1'b0;
    e.ovf = 1'b0;
    if (b == 29'd0) begin
      e.dz   = 1'b1;
      e.rem  = 30'd0;
      e.dout = (sa < 0) ? 30'h2000_0000 : 30'h1FFF_FFFF;
    end else begin
      qq = sa / sb_l;
      rr = sa % sb_l;
      qb = qq;
      rb = rr;
      e.dout = qb[29:0];
      e.rem  = rb[29:0];
`ifdef FPGA_TEST_STEP_DIV_SAT_EN
      if (qq > 64'sd536870911) begin
        e.dout = 30'h1FFF_FFFF;
        e.ovf  = 1'b1;
      end else if (qq < -64'sd536870912) begin
        e.dout = 30'h2000_0000;
        e.ovf  = 1'b1;
      end
`endif
    end
    return e;
  endfunction

  // Monitor: compare every presented result against the queue head.
  always @(negedge ap_clk) begin
    if (ap_rst_n && ap_done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: got ap_done=1, expected no pending result (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        $display("[TB] result dout=%0d rem=%0d dz=%0b ovf=%0b (exp %0d/%0d/%0b/%0b) latency=%0d",
                 $signed(dout), $signed(rem), dz, ovf,
                 $signed(mon_e.dout), $signed(mon_e.rem), mon_e.dz, mon_e.ovf, cyc - mon_e.acc);
        chk("dout",    64'(dout), 64'(mon_e.dout));
        chk("rem",     64'(rem),  64'(mon_e.rem));
        chk("dz",      64'(dz),   64'(mon_e.dz));
        chk("ovf",     64'(ovf),  64'(mon_e.ovf));
        chk("latency", 64'(cyc - mon_e.acc), 64'd59);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge ap_clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic start_op(input logic [57:0] a, input logic [28:0] b);
    int n = 0;
    @(negedge ap_clk);
    din0 = a;
    din1 = b;
    ap_start = 1'b1;
    #1;
    while (!ap_ready && n < 100) begin
      @(negedge ap_clk);
      #1;
      n++;
    end
    tests++;
    if (!ap_ready) begin
      fails++;
      $display("FAIL accept_timeout: got ap_ready=0, expected 1");
    end else begin
      sb.push_back(model(a, b, cyc));
    end
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
  endtask

  task automatic do_op(input logic [57:0] a, input logic [28:0] b);
    start_op(a, b);
    drain();
  endtask

  task automatic rand_operands(output logic [57:0] a, output logic [28:0] b);
    logic [63:0] r64;
    logic [31:0] r32;
    int sh;
    r64 = {$urandom, $urandom};
    sh  = $urandom_range(0, 57);
    a   = r64[57:0] >> sh;
    if ($urandom_range(0, 1) == 1) a = -a;
    r32 = $urandom;
    case ($urandom_range(0, 7))
      0:       b = 29'd0;
      1:       b = 29'h1FFF_FFFF;
      2, 3:    b = 29'($urandom_range(1, 15));
      default: b = r32[28:0];
    endcase
  endtask

  logic [57:0] da [6];
  logic [28:0] db [6];

  initial begin
    logic [57:0] ra;
    logic [28:0] rb;
    int n_acc;
    int last_acc;
    logic exp_rdy;

    da[0] = 58'd100;        db[0] = 29'd7;
    da[1] = -58'sd100;      db[1] = 29'd7;
    da[2] = 58'd1 << 57;    db[2] = 29'd1 << 28;
    da[3] = 58'd1 << 40;    db[3] = 29'd1;
    da[4] = 58'd5;          db[4] = 29'd0;
    da[5] = -58'sd5;        db[5] = 29'd0;

    // Asynchronous reset assertion between clock edges.
    #2 ap_rst_n = 1'b0;
    #1;
    chk("reset_idle", 64'(ap_idle), 64'd1);
    chk("reset_done", 64'(ap_done), 64'd0);
    chk("reset_dout", 64'(dout), 64'd0);
    chk("reset_rem",  64'(rem),  64'd0);
    chk("reset_dz",   64'(dz),   64'd0);
    chk("reset_ovf",  64'(ovf),  64'd0);
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;

    for (int i = 0; i < 6; i++) do_op(da[i], db[i]);

    // Reset mid-CALC: last result (dz case) is nonzero, so clearing is visible.
    start_op(58'd12345, 29'd17);
    repeat (20) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_idle", 64'(ap_idle), 64'd1);
    chk("midrst_done", 64'(ap_done), 64'd0);
    chk("midrst_dout", 64'(dout), 64'd0);
    chk("midrst_rem",  64'(rem),  64'd0);
    chk("midrst_dz",   64'(dz),   64'd0);
    chk("midrst_ovf",  64'(ovf),  64'd0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    do_op(58'd100, 29'd7);

    // Back-to-back with ap_start held and operands changing every cycle.
    n_acc = 0;
    last_acc = 0;
    for (int k = 0; k < 400 && n_acc < 3; k++) begin
      @(negedge ap_clk);
      rand_operands(ra, rb);
      din0 = ra;
      din1 = rb;
      ap_start = 1'b1;
      #1;
      exp_rdy = (n_acc == 0) ? 1'b1 : ((cyc - last_acc) == 60);
      chk("b2b_ready", 64'(ap_ready), 64'(exp_rdy));
      if (ap_ready) begin
        sb.push_back(model(ra, rb, cyc));
        last_acc = cyc;
        n_acc++;
      end
    end
    tests++;
    if (n_acc < 3) begin
      fails++;
      $display("FAIL b2b_accepts: got %0d, expected 3", n_acc);
    end
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    drain();

    // Randomized single operations.
    for (int i = 0; i < 25; i++) begin
      rand_operands(ra, rb);
      do_op(ra, rb);
    end

    repeat (3) @(negedge ap_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fpga_test_step_div_58s_29ns_30_seq.md
# fpga_test_step_div_58s_29ns_30_seq

Sequential signed-by-unsigned integer divider for the `fpga_test_step` datapath. It is the inverse of the 30s×29ns→58 product path: it takes a 58-bit signed dividend and a 29-bit unsigned divisor, and returns a 30-bit signed quotient and remainder. It computes one quotient bit per cycle using a restoring algorithm and uses the `ap_start`/`ap_done` block-level handshake, so HLS-generated FSMs can call it directly.

## Interface
Parameters:
- `din0_WIDTH`, 58: dividend width, signed.
- `din1_WIDTH`, 29: divisor width, unsigned (zero-extended internally).
- `dout_WIDTH`, 30: quotient and remainder width, signed.

Ports:
- `ap_clk`  in  1  the single clock; all state changes on its rising edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `ap_start`  in  1  request; sampled only in IDLE.
- `ap_ready`  out  1  operands consumed this cycle; equals `ap_start & ap_idle`.
- `ap_idle`  out  1  high in IDLE.
- `ap_done`  out  1  one-cycle pulse; results valid.
- `din0`  in  din0_WIDTH  dividend.
- `din1`  in  din1_WIDTH  divisor.
- `dout`  out  dout_WIDTH  quotient, truncated toward zero.
- `rem`  out  dout_WIDTH  remainder; takes the sign of the dividend; `|rem| < din1`.
- `dz`  out  1  divide-by-zero flag for the current result.
- `ovf`  out  1  quotient overflow flag for the current result.

## Operation
The FSM has three states: IDLE, CALC and DONE.
- **IDLE**
  - On `ap_start=1`: latch `|din0|` (58-bit magnitude), the sign of `din0` and `din1`.
  - Load the bit counter with `din0_WIDTH-1`, clear the partial remainder and go to CALC.
  - If `din1==0`: set an internal dz flag. CALC still runs; its datapath result is discarded.
- **CALC**, one iteration per cycle:
  - `r = {r, msb(n)}`; shift `n` left.
  - If `r >= d`: `r -= d` and the quotient bit is 1; otherwise the quotient bit is 0.
  - `r` is 30 bits wide and the quotient shift register is 58 bits wide.
  - When the counter reaches 0, go to DONE; otherwise decrement the counter.
- **DONE**
  - Register the outputs and pulse `ap_done`.
  - Go to IDLE unconditionally; `ap_start` is ignored in DONE.

Result rules:
- Quotient and remainder are negated when the dividend is negative; the divisor is always non-negative.
- Overflow occurs when the signed quotient lies outside [-2^29, 2^29-1].
- Divide by zero gives `dz=1`, `rem=0`, and `dout` equal to 2^29-1 (dividend ≥ 0) or -2^29 (dividend < 0). `ovf=0` in this case.
- `ap_start` during CALC or DONE has no effect; no operands are latched.
- `dout`, `rem`, `dz` and `ovf` hold their values from DONE until the next DONE.

## Timing
- **Reset**: `ap_rst_n` low immediately (asynchronously) forces:
  - state IDLE, so `ap_idle=1`;
  - `ap_done=0`;
  - `dout=0`, `rem=0`, `dz=0`, `ovf=0`;
  - counter and internal registers cleared.
- **Reset mid-CALC**: the operation is aborted, no `ap_done` is issued, and the block accepts a new start on the first edge after release.
- **Latency**:
  - Acceptance edge is cycle 0.
  - CALC occupies cycles 1–58.
  - `ap_done=1` and results are valid in cycle 59.
  - `ap_idle=1` in cycle 60.
- **Throughput**: with `ap_start` held high, one result every 60 cycles.
- **Output timing**: `ap_idle` is decoded from the state register. `ap_ready` is combinational from `ap_start`. All other outputs are registered.

## Configuration
- Macro: `FPGA_TEST_STEP_DIV_SAT_EN`.
- Defined:
  - an overflowing quotient saturates to 2^29-1 (positive) or -2^29 (negative);
  - `ovf=1`;
  - `rem` still carries the true remainder.
- Undefined:
  - `dout` is the low 30 bits of the two's-complement quotient, with no saturation;
  - `ovf` is tied to 0;
  - divide-by-zero handling is unchanged.

## Test plan
- **Basic positive**: `din0=100`, `din1=7`, one start pulse -> `ap_done` 59 cycles after acceptance; `dout=14`, `rem=2`, `dz=0`, `ovf=0`.
- **Negative dividend**: `din0=-100`, `din1=7` -> `dout=-14`, `rem=-2`. With `din0=-(2^57)` and `din1=2^28` -> `dout=-2^29`, `rem=0`, `ovf=0`.
- **Divide by zero**:
  - `din0=5`, `din1=0` -> `dout=536870911`, `rem=0`, `dz=1`.
  - `din0=-5`, `din1=0` -> `dout=-536870912`, `dz=1`.
- **Overflow**: `din0=2^40`, `din1=1`:
  - with the macro -> `dout=536870911`, `ovf=1`, `rem=0`;
  - without the macro -> `dout=0`, `ovf=0`.
- **Reset mid-CALC**: drop `ap_rst_n` 20 cycles into an operation -> all outputs 0, `ap_idle=1` immediately, no `ap_done`. A following start on 100/7 yields 14 after 59 cycles.
- **Back-to-back**: `ap_start` held high with operands changed each cycle:
  - `ap_ready` pulses only in IDLE cycles;
  - `ap_done` pulses every 60 cycles;
  - each result matches the operands present on its `ap_ready` cycle;
  - operand changes during CALC are ignored.
